// File: rtl/lowx_mem_arbiter.sv
// Arbiter sharing one lower-level memory port between the icache refill path and the
// dcache refill/writeback path; one transaction in flight, dcache priority with starvation guard.
module lowx_mem_arbiter #(
    parameter int XLEN       = 32,
    parameter int BLK_SIZE   = 128,
    parameter int MAX_STARVE = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ic_flush_i,
    input  logic                ic_req_valid_i,
    input  logic [XLEN-1:0]     ic_req_addr_i,
    output logic                ic_req_ready_o,
    output logic                ic_res_valid_o,
    output logic [BLK_SIZE-1:0] ic_res_blk_o,
    input  logic                dc_req_valid_i,
    input  logic [XLEN-1:0]     dc_req_addr_i,
    input  logic                dc_req_rw_i,
    input  logic [BLK_SIZE-1:0] dc_req_data_i,
    output logic                dc_req_ready_o,
    output logic                dc_res_valid_o,
    output logic [BLK_SIZE-1:0] dc_res_blk_o,
    output logic                mem_req_valid_o,
    output logic [XLEN-1:0]     mem_req_addr_o,
    output logic                mem_req_rw_o,
    output logic [BLK_SIZE-1:0] mem_req_data_o,
    input  logic                mem_req_ready_i,
    input  logic                mem_res_valid_i,
    input  logic [BLK_SIZE-1:0] mem_res_blk_i
);

    localparam int CW = $clog2(MAX_STARVE + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_t;

    state_t              state_q;
    state_t              state_d;
    owner_t              owner_q;
    logic [CW-1:0]       starve_cnt;
    logic                drop_q;
    logic [XLEN-1:0]     addr_q;
    logic                rw_q;
    logic [BLK_SIZE-1:0] data_q;

    logic ic_eligible;
    logic force_ic;
    logic grant_dc;
    logic grant_ic;
    logic res_done;

    // Grant is only offered in IDLE; rst_ni gating keeps ready pulses off while reset is held.
    always_comb begin
        ic_eligible = ic_req_valid_i && !ic_flush_i;
        force_ic    = ic_eligible && (starve_cnt == CW'(MAX_STARVE));
        grant_dc    = rst_ni && (state_q == S_IDLE) && dc_req_valid_i && !force_ic;
        grant_ic    = rst_ni && (state_q == S_IDLE) && ic_eligible && !grant_dc;
        res_done    = (state_q == S_WAIT) && mem_res_valid_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (grant_dc || grant_ic) state_d = S_REQ;
            S_REQ:  if (mem_req_ready_i)      state_d = S_WAIT;
            S_WAIT: if (mem_res_valid_i)      state_d = S_IDLE;
            default:                          state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ic_req_ready_o  = grant_ic;
        dc_req_ready_o  = grant_dc;
        mem_req_valid_o = 1'b0;
        mem_req_addr_o  = '0;
        mem_req_rw_o    = 1'b0;
        mem_req_data_o  = '0;
        ic_res_valid_o  = 1'b0;
        ic_res_blk_o    = '0;
        dc_res_valid_o  = 1'b0;
        dc_res_blk_o    = '0;
        if (state_q == S_REQ) begin
            mem_req_valid_o = 1'b1;
            mem_req_addr_o  = addr_q;
            mem_req_rw_o    = rw_q;
            mem_req_data_o  = data_q;
        end
        // A flush arriving with the response itself must also suppress it, hence the live ic_flush_i term.
        if (res_done) begin
            if (owner_q == OWN_DC) begin
                dc_res_valid_o = 1'b1;
                dc_res_blk_o   = mem_res_blk_i;
            end else if (!drop_q && !ic_flush_i) begin
                ic_res_valid_o = 1'b1;
                ic_res_blk_o   = mem_res_blk_i;
            end
        end
    end

    // Request fields are captured only in the grant cycle; icache transactions never write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q <= OWN_IC;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            data_q  <= '0;
        end else if (grant_dc) begin
            owner_q <= OWN_DC;
            addr_q  <= dc_req_addr_i;
            rw_q    <= dc_req_rw_i;
            data_q  <= dc_req_data_i;
        end else if (grant_ic) begin
            owner_q <= OWN_IC;
            addr_q  <= ic_req_addr_i;
            rw_q    <= 1'b0;
            data_q  <= '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt <= '0;
        end else if (grant_ic) begin
            starve_cnt <= '0;
        end else if (grant_dc && ic_req_valid_i && (starve_cnt != CW'(MAX_STARVE))) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

    // Dropped icache transactions still run to completion on the memory side.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_q <= 1'b0;
        end else if (res_done) begin
            drop_q <= 1'b0;
        end else if (ic_flush_i && (owner_q == OWN_IC) &&
                     ((state_q == S_REQ) || (state_q == S_WAIT))) begin
            drop_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lowx_mem_arbiter.sv
// Directed testbench for lowx_mem_arbiter: reset, icache read, starvation order,
// dcache writeback hold, icache flush handling.
module tb_lowx_mem_arbiter;

    localparam int XLEN     = 32;
    localparam int BLK_SIZE = 128;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic                ic_flush_i;
    logic                ic_req_valid_i;
    logic [XLEN-1:0]     ic_req_addr_i;
    logic                ic_req_ready_o;
    logic                ic_res_valid_o;
    logic [BLK_SIZE-1:0] ic_res_blk_o;
    logic                dc_req_valid_i;
    logic [XLEN-1:0]     dc_req_addr_i;
    logic                dc_req_rw_i;
    logic [BLK_SIZE-1:0] dc_req_data_i;
    logic                dc_req_ready_o;
    logic                dc_res_valid_o;
    logic [BLK_SIZE-1:0] dc_res_blk_o;
    logic                mem_req_valid_o;
    logic [XLEN-1:0]     mem_req_addr_o;
    logic                mem_req_rw_o;
    logic [BLK_SIZE-1:0] mem_req_data_o;
    logic                mem_req_ready_i;
    logic                mem_res_valid_i;
    logic [BLK_SIZE-1:0] mem_res_blk_i;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    lowx_mem_arbiter #(.XLEN(XLEN), .BLK_SIZE(BLK_SIZE), .MAX_STARVE(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .ic_flush_i(ic_flush_i),
        .ic_req_valid_i(ic_req_valid_i), .ic_req_addr_i(ic_req_addr_i),
        .ic_req_ready_o(ic_req_ready_o), .ic_res_valid_o(ic_res_valid_o),
        .ic_res_blk_o(ic_res_blk_o), .dc_req_valid_i(dc_req_valid_i),
        .dc_req_addr_i(dc_req_addr_i), .dc_req_rw_i(dc_req_rw_i),
        .dc_req_data_i(dc_req_data_i), .dc_req_ready_o(dc_req_ready_o),
        .dc_res_valid_o(dc_res_valid_o), .dc_res_blk_o(dc_res_blk_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_req_rw_o(mem_req_rw_o), .mem_req_data_o(mem_req_data_o),
        .mem_req_ready_i(mem_req_ready_i), .mem_res_valid_i(mem_res_valid_i),
        .mem_res_blk_i(mem_res_blk_i)
    );

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Drives the memory side from REQ through to a response held for one settle step.
    task automatic run_mem(input int ready_delay, input int res_delay, input logic [BLK_SIZE-1:0] blk);
        repeat (ready_delay) cycle();
        mem_req_ready_i = 1'b1;
        cycle();
        mem_req_ready_i = 1'b0;
        repeat (res_delay) cycle();
        mem_res_valid_i = 1'b1;
        mem_res_blk_i   = blk;
        #1;
    endtask

    task automatic finish_res();
        cycle();
        mem_res_valid_i = 1'b0;
        mem_res_blk_i   = '0;
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        ic_flush_i = 0; ic_req_valid_i = 0; ic_req_addr_i = '0;
        dc_req_valid_i = 0; dc_req_addr_i = '0; dc_req_rw_i = 0; dc_req_data_i = '0;
        mem_req_ready_i = 0; mem_res_valid_i = 0; mem_res_blk_i = '0;
        cycle();
        cycle();
        checks++;
        if ({mem_req_valid_o, mem_req_rw_o, ic_req_ready_o, dc_req_ready_o, ic_res_valid_o, dc_res_valid_o} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000000",
                     {mem_req_valid_o, mem_req_rw_o, ic_req_ready_o, dc_req_ready_o, ic_res_valid_o, dc_res_valid_o});
        end
        checks++;
        if (mem_req_addr_o !== '0 || mem_req_data_o !== '0 || ic_res_blk_o !== '0 || dc_res_blk_o !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: addr %h data %h expected 0", mem_req_addr_o, mem_req_data_o);
        end
        rst_ni = 1'b1;
        cycle();
        ic_req_valid_i = 1'b1;
        ic_req_addr_i  = 32'h8000_0000;
        cycle();
        ic_req_valid_i = 1'b0;
        checks++;
        if (mem_req_valid_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_pre_req: got %b expected 1", mem_req_valid_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (mem_req_valid_o !== 1'b0 || mem_req_addr_o !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_req: valid %b addr %h expected 0", mem_req_valid_o, mem_req_addr_o);
        end
        cycle();
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (ic_req_ready_o !== 1'b0 || dc_req_ready_o !== 1'b0 || mem_req_valid_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_idle: ic_rdy %b dc_rdy %b mem_v %b expected 0",
                         ic_req_ready_o, dc_req_ready_o, mem_req_valid_o);
            end
        end
    endtask

    task automatic test_ic_read();
        ic_req_valid_i = 1'b1;
        ic_req_addr_i  = 32'h8000_0040;
        #1;
        checks++;
        if (ic_req_ready_o !== 1'b1 || dc_req_ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ic_grant: ic_rdy %b dc_rdy %b expected 1 0", ic_req_ready_o, dc_req_ready_o);
        end
        cycle();
        ic_req_valid_i = 1'b0;
        ic_req_addr_i  = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 32'h8000_0040 || mem_req_rw_o !== 1'b0 || mem_req_data_o !== '0) begin
            errors++;
            $display("[TB] FAIL ic_mem_req: valid %b addr %h rw %b expected 1 80000040 0",
                     mem_req_valid_o, mem_req_addr_o, mem_req_rw_o);
        end
        cycle();
        mem_req_ready_i = 1'b1;
        cycle();
        mem_req_ready_i = 1'b0;
        #1;
        checks++;
        if (mem_req_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ic_wait_valid: got %b expected 0", mem_req_valid_o);
        end
        cycle();
        cycle();
        mem_res_valid_i = 1'b1;
        mem_res_blk_i   = {16{8'hA5}};
        #1;
        checks++;
        if (ic_res_valid_o !== 1'b1 || ic_res_blk_o !== {16{8'hA5}} || dc_res_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ic_res: valid %b blk %h dc_valid %b expected 1 a5..a5 0",
                     ic_res_valid_o, ic_res_blk_o, dc_res_valid_o);
        end
        finish_res();
        checks++;
        if (ic_res_valid_o !== 1'b0 || mem_req_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ic_res_pulse: res %b mem_v %b expected 0 0", ic_res_valid_o, mem_req_valid_o);
        end
    endtask

    task automatic test_starvation();
        logic       exp_dc [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0] exp_cnt [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        logic       got_ic;
        ic_req_valid_i = 1'b1;
        ic_req_addr_i  = 32'h8000_0100;
        dc_req_valid_i = 1'b1;
        dc_req_addr_i  = 32'h8000_2000;
        dc_req_rw_i    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (dc_req_ready_o !== exp_dc[i] || ic_req_ready_o !== !exp_dc[i]) begin
                errors++;
                $display("[TB] FAIL starve_order[%0d]: dc_rdy %b ic_rdy %b expected dc_rdy %b",
                         i, dc_req_ready_o, ic_req_ready_o, exp_dc[i]);
            end
            got_ic = ic_req_ready_o;
            cycle();
            if (got_ic) begin
                ic_req_valid_i = 1'b0;
                dc_req_valid_i = 1'b0;
            end
            checks++;
            if (dut.starve_cnt !== exp_cnt[i]) begin
                errors++;
                $display("[TB] FAIL starve_cnt[%0d]: got %0d expected %0d", i, dut.starve_cnt, exp_cnt[i]);
            end
            run_mem(0, 1, 128'(i));
            finish_res();
        end
    endtask

    task automatic test_dc_write();
        logic [BLK_SIZE-1:0] wdata = 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978;
        dc_req_valid_i = 1'b1;
        dc_req_addr_i  = 32'h8000_1000;
        dc_req_rw_i    = 1'b1;
        dc_req_data_i  = wdata;
        #1;
        checks++;
        if (dc_req_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL dc_grant: got %b expected 1", dc_req_ready_o);
        end
        cycle();
        dc_req_valid_i = 1'b0;
        dc_req_data_i  = '1;
        dc_req_rw_i    = 1'b0;
        ic_flush_i     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (mem_req_valid_o !== 1'b1 || mem_req_rw_o !== 1'b1 || mem_req_addr_o !== 32'h8000_1000 || mem_req_data_o !== wdata) begin
                errors++;
                $display("[TB] FAIL dc_hold[%0d]: valid %b rw %b addr %h data %h expected 1 1 80001000 %h",
                         i, mem_req_valid_o, mem_req_rw_o, mem_req_addr_o, mem_req_data_o, wdata);
            end
            cycle();
        end
        run_mem(0, 0, '0);
        checks++;
        if (dc_res_valid_o !== 1'b1 || ic_res_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dc_ack: dc %b ic %b expected 1 0", dc_res_valid_o, ic_res_valid_o);
        end
        finish_res();
        ic_flush_i = 1'b0;
        checks++;
        if (dc_res_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dc_ack_pulse: got %b expected 0", dc_res_valid_o);
        end
    endtask

    task automatic test_flush();
        ic_req_valid_i = 1'b1;
        ic_req_addr_i  = 32'h8000_0080;
        #1;
        cycle();
        ic_req_valid_i = 1'b0;
        mem_req_ready_i = 1'b1;
        cycle();
        mem_req_ready_i = 1'b0;
        ic_flush_i = 1'b1;
        cycle();
        ic_flush_i = 1'b0;
        cycle();
        mem_res_valid_i = 1'b1;
        mem_res_blk_i   = {16{8'h3C}};
        #1;
        checks++;
        if (ic_res_valid_o !== 1'b0 || dc_res_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_drop: ic %b dc %b expected 0 0", ic_res_valid_o, dc_res_valid_o);
        end
        finish_res();
        ic_req_valid_i = 1'b1;
        ic_req_addr_i  = 32'h8000_00C0;
        #1;
        checks++;
        if (ic_req_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_regrant: got %b expected 1", ic_req_ready_o);
        end
        cycle();
        ic_req_valid_i = 1'b0;
        run_mem(0, 0, {16{8'h5A}});
        checks++;
        if (ic_res_valid_o !== 1'b1 || ic_res_blk_o !== {16{8'h5A}}) begin
            errors++;
            $display("[TB] FAIL flush_next_res: valid %b blk %h expected 1 5a..5a", ic_res_valid_o, ic_res_blk_o);
        end
        finish_res();
    endtask

    task automatic test_flush_idle();
        ic_req_valid_i = 1'b1;
        ic_flush_i     = 1'b1;
        ic_req_addr_i  = 32'h8000_0200;
        #1;
        checks++;
        if (ic_req_ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_idle_rdy: got %b expected 0", ic_req_ready_o);
        end
        cycle();
        checks++;
        if (mem_req_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_idle_mem: got %b expected 0", mem_req_valid_o);
        end
        ic_req_valid_i = 1'b0;
        ic_flush_i     = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ic_read();
        test_starvation();
        test_dc_write();
        test_flush();
        test_flush_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
